// File: rtl/sfp_pkg.sv
// Shared types and default sizing for the
// special-function normalise stage.
package sfp_pkg;

  localparam int COL     = 8;
  localparam int BW_PSUM = 20;
  localparam int FRAC    = 8;

  localparam int SUM_W = BW_PSUM + 3;
  localparam int ABS_W = BW_PSUM + 1;
  localparam int QUO_W = FRAC + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/sfp_div.sv
// Serial restoring divider: q = floor(a*2^(qw-1)/s), a <= s.
// Iteration 0 runs in the start cycle; done flags the last.
module sfp_div
  import sfp_pkg::*;
#(
  parameter int sw = SUM_W,
  parameter int aw = ABS_W,
  parameter int qw = QUO_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [aw-1:0] a,
  input  logic [sw-1:0] s,
  output logic          done,
  output logic [qw-1:0] q
);

  localparam int CW = $clog2(qw);

  logic [sw:0]   rem;
  logic [sw:0]   cur;
  logic [sw:0]   nrem;
  logic [qw-1:0] quo;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          ge;

  always_comb begin
    cur  = start ? {{(sw + 1 - aw){1'b0}}, a} : rem;
    ge   = cur >= {1'b0, s};
    nrem = ge ? cur - {1'b0, s} : cur;
    done = busy && (cnt == CW'(qw - 1));
    q    = {quo[qw-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {nrem[sw-1:0], 1'b0};
      quo  <= {{(qw - 1){1'b0}}, ge};
      cnt  <= CW'(1);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= {nrem[sw-1:0], 1'b0};
      quo <= q;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/sfp_norm.sv
// Row abs-sum and lane-wise normalisation to a signed
// fixed-point fraction of that sum.
module sfp_norm
  import sfp_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int frac    = FRAC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw_psum*col-1:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [bw_psum*col-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bw_psum+3:0]     sum_out
);

  localparam int SW = bw_psum + 3;
  localparam int AW = bw_psum + 1;
  localparam int QW = frac + 1;
  localparam int LW = $clog2(col);

  state_t state;
  state_t nxt;

  logic [bw_psum*col-1:0] row;
  logic [SW-1:0]          sum_q;
  logic [SW-1:0]          total;
  logic [LW-1:0]          lane;
  logic                   run;
  logic                   start;
  logic                   done;
  logic [QW-1:0]          q;
  logic [AW-1:0]          abs_l [col];
  logic                   neg_l [col];
  logic [AW-1:0]          sx;
  logic [bw_psum-1:0]     qx;
  logic [bw_psum-1:0]     res;

  // Abs on one extra bit so the most negative lane is exact
  always_comb begin
    total = '0;
    sx    = '0;
    for (int i = 0; i < col; i++) begin
      sx       = {row[bw_psum*(i+1)-1], row[bw_psum*i +: bw_psum]};
      neg_l[i] = sx[AW-1];
      abs_l[i] = sx[AW-1] ? AW'(0) - sx : sx;
      total    = total + SW'(abs_l[i]);
    end
  end

  assign start    = (state == DIV) && !run;
  assign in_ready = (state == IDLE) && reset;
  assign sum_out  = {1'b0, sum_q};

  always_comb begin
    qx  = {{(bw_psum - QW){1'b0}}, q};
    res = neg_l[lane] ? bw_psum'(0) - qx : qx;
  end

  sfp_div #(
    .sw(SW),
    .aw(AW),
    .qw(QW)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (abs_l[lane]),
    .s    (sum_q),
    .done (done),
    .q    (q)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (in_valid) nxt = SUM;
      SUM:  nxt = (total != '0) ? DIV : OUT;
      DIV:  if (done && lane == LW'(col - 1)) nxt = OUT;
      OUT:  if (out_valid && out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      sum_q     <= '0;
      lane      <= '0;
      run       <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        row  <= in;
        lane <= '0;
      end
      if (state == SUM) begin
        sum_q <= total;
        if (total == '0) out <= '0;
      end
      if (start) run <= 1'b1;
      else if (done) run <= 1'b0;
      if (done) begin
        out[lane*bw_psum +: bw_psum] <= res;
        lane <= lane + LW'(1);
      end
      // Valid rises one cycle into OUT, drops on transfer
      if (state == OUT) begin
        if (!out_valid) out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfp_norm.sv
// Directed bench for sfp_norm: sums, quotients, latency,
// backpressure and mid-divide reset.
module tb_sfp_norm;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [159:0] in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [159:0] out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [23:0]  sum_out;

  int tests = 0;
  int fails = 0;

  logic [159:0] r100, e32, r400, e128, rz, r3, e3, hold;

  always #5 clk = ~clk;

  sfp_norm dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_out  (sum_out)
  );

  function automatic logic [159:0] mk(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    mk = {20'(a7), 20'(a6), 20'(a5), 20'(a4),
          20'(a3), 20'(a2), 20'(a1), 20'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs,
                     input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [159:0] r);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("acc_ready", in_ready, 1);
    in = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [23:0] es,
                          input logic [159:0] eo, input int lat);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) chk({tag, "_sum1"}, sum_out, es);
    end while (!out_valid && n < 200);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_sum"}, sum_out, es);
  endtask

  task automatic hs(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_vdrop"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    r100 = mk(100, 100, 100, 100, 100, 100, 100, 100);
    e32  = mk(32, 32, 32, 32, 32, 32, 32, 32);
    r400 = mk(400, -400, 0, 0, 0, 0, 0, 0);
    e128 = mk(128, -128, 0, 0, 0, 0, 0, 0);
    rz   = '0;
    r3   = mk(0, 0, 0, -524288, 0, 0, 0, 0);
    e3   = mk(0, 0, 0, -256, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_out", out, 0);
    chk("rst_inrdy", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_rdy", in_ready, 1);

    accept(r100);
    wait_out("all100", 24'd800, e32, 74);
    hs("all100");

    accept(r400);
    wait_out("pm400", 24'd800, e128, 74);
    chk("pm400_lane1", out[39:20], 20'hFFF80);
    hs("pm400");

    accept(rz);
    wait_out("zero", 24'd0, '0, 2);
    hs("zero");

    accept(r3);
    wait_out("minlane", 24'd524288, e3, 74);
    hs("minlane");

    accept(r100);
    wait_out("bp", 24'd800, e32, 74);
    hold = out;
    in = r400;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_inrdy", in_ready, 0);
      chk("bp_out", out, hold);
      chk("bp_sum", sum_out, 24'd800);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_vdrop", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_taken", in_ready, 0);
    wait_out("bp_new", 24'd800, e128, 74);
    hs("bp_new");

    accept(r3);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_sum", sum_out, 0);
    chk("mrst_out", out, 0);
    chk("mrst_rdy", in_ready, 1);
    accept(r100);
    wait_out("after_rst", 24'd800, e32, 74);
    hs("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
